// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial adder.
// Holds the state encoding and the nibble index sizing helper.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/carry_lookahead_4bits.sv
// 4-bit carry-lookahead adder slice.
// Purely combinational; generate/propagate form.
module carry_lookahead_4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s    = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder/subtractor: one CLA slice pass per nibble,
// least significant nibble first, carry kept in a register.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IW = idx_w(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_t state;
   state_t state_n;

   logic [NIBBLES-1:0][NIBBLE_W-1:0] opa;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] opb;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] acc;
   logic [IW-1:0]                    idx;
   logic                             carry;
   logic                             a_msb;
   logic                             b_msb;
   logic [NIBBLE_W-1:0]              s_nib;
   logic                             s_cout;
   logic                             accept;

   carry_lookahead_4bits u_cla (
      .a    (opa[idx]),
      .b    (opb[idx]),
      .cin  (carry),
      .s    (s_nib),
      .cout (s_cout)
   );

   assign accept = (state == IDLE) && in_valid;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid)     state_n = RUN;
         RUN:     if (idx == LAST)  state_n = DONE;
         DONE:    if (out_ready)    state_n = IDLE;
         default:                   state_n = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1, so b is inverted at capture time.
   always_ff @(posedge clk) begin
      if (reset) begin
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub | cin;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1] ^ sub;
         idx   <= '0;
      end else if (state == RUN) begin
         acc[idx] <= s_nib;
         carry    <= s_cout;
         idx      <= idx + IW'(1);
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = acc;
   assign cout      = out_valid & carry;
   assign overflow  = out_valid & (a_msb == b_msb)
                    & (acc[NIBBLES-1][NIBBLE_W-1] != a_msb);

endmodule
